// File: rtl/ps2_keymap_decoder.sv
// PS/2 set-2 scan-code decoder: tracks make/break/extended prefixes, Shift and
// Caps Lock, and queues case-correct ASCII into a first-word-fall-through FIFO.
module ps2_keymap_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int AUTOREPEAT = 1
) (
  input  logic       i_clk,
  input  logic       i_clrn,
  input  logic [7:0] i_scan_code,
  input  logic       i_scan_valid,
  input  logic       i_rd_en,
  output logic [7:0] o_ascii,
  output logic       o_ascii_valid,
  output logic       o_shift_held,
  output logic       o_caps_on,
  output logic       o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      r_state;
  logic        r_shl, r_shr, r_caps, r_ovf, r_push;
  logic [7:0]  r_held, r_push_data;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;

  logic [7:0]  w_char;
  logic        w_full, w_empty, w_pop, w_wr;

  function automatic logic [7:0] f_lookup(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [7:0] lc;
    logic [7:0] ch;
    lc = 8'h00;
    ch = 8'h00;
    case (code)
      8'h1C: lc = "a"; 8'h32: lc = "b"; 8'h21: lc = "c"; 8'h23: lc = "d";
      8'h24: lc = "e"; 8'h2B: lc = "f"; 8'h34: lc = "g"; 8'h33: lc = "h";
      8'h43: lc = "i"; 8'h3B: lc = "j"; 8'h42: lc = "k"; 8'h4B: lc = "l";
      8'h3A: lc = "m"; 8'h31: lc = "n"; 8'h44: lc = "o"; 8'h4D: lc = "p";
      8'h15: lc = "q"; 8'h2D: lc = "r"; 8'h1B: lc = "s"; 8'h2C: lc = "t";
      8'h3C: lc = "u"; 8'h2A: lc = "v"; 8'h1D: lc = "w"; 8'h22: lc = "x";
      8'h35: lc = "y"; 8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) begin
      ch = (shift ^ caps) ? lc - 8'h20 : lc;
    end else begin
      // digits and whitespace ignore Caps Lock
      case (code)
        8'h16: ch = shift ? "!" : "1";
        8'h1E: ch = shift ? "@" : "2";
        8'h26: ch = shift ? "#" : "3";
        8'h25: ch = shift ? "$" : "4";
        8'h2E: ch = shift ? "%" : "5";
        8'h36: ch = shift ? "^" : "6";
        8'h3D: ch = shift ? "&" : "7";
        8'h3E: ch = shift ? "*" : "8";
        8'h46: ch = shift ? "(" : "9";
        8'h45: ch = shift ? ")" : "0";
        8'h29: ch = 8'h20;
        8'h5A: ch = 8'h0D;
        8'h66: ch = 8'h08;
        default: ch = 8'h00;
      endcase
    end
    return ch;
  endfunction

  assign w_char  = f_lookup(i_scan_code, r_shl | r_shr, r_caps);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_DEPTH);
  assign w_pop   = i_rd_en && !w_empty;
  assign w_wr    = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_state     <= IDLE;
      r_shl       <= 1'b0;
      r_shr       <= 1'b0;
      r_caps      <= 1'b0;
      r_held      <= 8'h00;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_push <= 1'b0;
      if (i_scan_valid) begin
        case (r_state)
          IDLE: begin
            if (i_scan_code == 8'hF0) r_state <= BRK;
            else if (i_scan_code == 8'hE0) r_state <= EXT;
            else begin
              r_held <= i_scan_code;
              case (i_scan_code)
                8'h12: r_shl <= 1'b1;
                8'h59: r_shr <= 1'b1;
                8'h58: if (r_held != 8'h58) r_caps <= ~r_caps;
                default: begin
                  if ((AUTOREPEAT != 0 || i_scan_code != r_held) && w_char != 8'h00) begin
                    r_push      <= 1'b1;
                    r_push_data <= w_char;
                  end
                end
              endcase
            end
          end
          BRK: begin
            r_state <= IDLE;
            if (i_scan_code == 8'h12) r_shl <= 1'b0;
            if (i_scan_code == 8'h59) r_shr <= 1'b0;
            if (i_scan_code == r_held) r_held <= 8'h00;
          end
          EXT:     r_state <= (i_scan_code == 8'hF0) ? EXT_BRK : IDLE;
          EXT_BRK: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (r_push && !w_wr) r_ovf <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= r_push_data;
  end

  assign o_ascii       = w_empty ? 8'h00 : r_mem[r_rptr];
  assign o_ascii_valid = !w_empty;
  assign o_shift_held  = r_shl | r_shr;
  assign o_caps_on     = r_caps;
  assign o_overflow    = r_ovf;
endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Bench for ps2_keymap_decoder: two instances (depth 8/autorepeat, depth 4/no
// autorepeat) share stimulus; each is compared against a key-event model.
module tb_ps2_keymap_decoder;
  logic       clk, clrn, sv, rd;
  logic [7:0] sc;
  logic [7:0] asc [2];
  logic       av [2], sh [2], cp [2], ov [2];

  int vecs = 0;
  int errs = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ps2_keymap_decoder #(.FIFO_DEPTH(g == 0 ? 8 : 4), .AUTOREPEAT(g == 0 ? 1 : 0)) u_dut (
      .i_clk(clk), .i_clrn(clrn), .i_scan_code(sc), .i_scan_valid(sv), .i_rd_en(rd),
      .o_ascii(asc[g]), .o_ascii_valid(av[g]), .o_shift_held(sh[g]),
      .o_caps_on(cp[g]), .o_overflow(ov[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  localparam logic [7:0] LET_CODE [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,
    8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,
    8'h1D,8'h22,8'h35,8'h1A};
  localparam logic [7:0] DIG_CODE [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  localparam logic [7:0] DIG_HI [10] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29};
  localparam logic [7:0] MISC [9] = '{8'h12,8'h59,8'h58,8'hE0,8'h29,8'h5A,8'h66,8'h75,8'h05};
  localparam int DEP [2] = '{8, 4};

  // model state: keyboard view plus one character list per instance
  logic       m_brk, m_ext, m_shl, m_shr, m_caps;
  logic [7:0] m_held;
  logic [7:0] mf [2][8];
  int         mcnt [2];
  logic       movf [2];
  logic       pend_v [2];
  logic [7:0] pend [2];

  function automatic logic [7:0] ref_char(input logic [7:0] c, input logic s, input logic k);
    for (int i = 0; i < 26; i++)
      if (LET_CODE[i] == c) return (s ^ k) ? 8'h41 + 8'(i) : 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++)
      if (DIG_CODE[i] == c) return s ? DIG_HI[i] : (i == 9 ? 8'h30 : 8'h31 + 8'(i));
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_head(input int d);
    return (mcnt[d] > 0) ? mf[d][0] : 8'h00;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_held = 8'h00;
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; movf[d] = 0; pend_v[d] = 0; pend[d] = 8'h00;
    end
  endtask

  task automatic model_byte(input logic [7:0] c);
    logic [7:0] ch;
    if (!m_brk && !m_ext) begin
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else begin
        if (c == 8'h12) m_shl = 1;
        else if (c == 8'h59) m_shr = 1;
        else if (c == 8'h58) begin
          if (m_held != 8'h58) m_caps = !m_caps;
        end else begin
          ch = ref_char(c, m_shl | m_shr, m_caps);
          for (int d = 0; d < 2; d++)
            if (ch != 8'h00 && (d == 0 || c != m_held)) begin
              pend_v[d] = 1; pend[d] = ch;
            end
        end
        m_held = c;
      end
    end else if (m_ext && !m_brk) begin
      if (c == 8'hF0) m_brk = 1; else m_ext = 0;
    end else if (m_ext && m_brk) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_brk = 0;
      if (c == 8'h12) m_shl = 0;
      if (c == 8'h59) m_shr = 0;
      if (c == m_held) m_held = 8'h00;
    end
  endtask

  task automatic model_fifo(input logic r);
    for (int d = 0; d < 2; d++) begin
      if (r && mcnt[d] > 0) begin
        for (int k = 0; k < 7; k++) mf[d][k] = mf[d][k+1];
        mcnt[d]--;
      end
      if (pend_v[d]) begin
        if (mcnt[d] < DEP[d]) begin mf[d][mcnt[d]] = pend[d]; mcnt[d]++; end
        else movf[d] = 1;
      end
      pend_v[d] = 0;
    end
  endtask

  // one clock edge; the model sees the FIFO commit of the prior byte, then this byte
  task automatic clk_edge(input logic v, input logic [7:0] c, input logic r);
    sv = v; sc = c; rd = r;
    @(posedge clk); #1;
    model_fifo(r);
    if (v) model_byte(c);
    sv = 1'b0; rd = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic pop_at_push);
    clk_edge(1'b1, c, 1'b0);
    clk_edge(1'b0, 8'h00, pop_at_push);
  endtask

  task automatic do_reset();
    clrn = 1'b0; sv = 1'b1; sc = 8'h1C; rd = 1'b1;
    @(posedge clk); #1;
    model_reset();
    clrn = 1'b1; sv = 1'b0; rd = 1'b0;
  endtask

  function automatic logic [7:0] pick_code();
    case ($urandom_range(0, 5))
      0: return LET_CODE[$urandom_range(0, 25)];
      1: return DIG_CODE[$urandom_range(0, 9)];
      2, 5: return 8'hF0;
      3: return MISC[$urandom_range(0, 8)];
      default: return LET_CODE[$urandom_range(0, 3)];
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b0 || asc[d] !== 8'h00 || sh[d] !== 1'b0 || cp[d] !== 1'b0 || ov[d] !== 1'b0) begin
        errs++;
        $display("FAIL reset d%0d: got v%b a%h s%b c%b o%b, required all zero", d, av[d], asc[d], sh[d], cp[d], ov[d]);
      end
    end
  endtask

  task automatic test_make_break();
    do_reset();
    clk_edge(1'b1, 8'h1C, 1'b0);
    vecs++;
    if (av[0] !== 1'b0) begin errs++; $display("FAIL latency_early: got valid %b, required 0", av[0]); end
    clk_edge(1'b0, 8'h00, 1'b0);
    vecs++;
    if (av[0] !== 1'b1 || asc[0] !== 8'h61) begin
      errs++; $display("FAIL latency_char: got v%b a%h, required v1 a61", av[0], asc[0]);
    end
    send(8'hF0, 0); send(8'h1C, 0);
    clk_edge(1'b0, 8'h00, 1'b1);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b0 || asc[d] !== 8'h00) begin
        errs++; $display("FAIL pop_empty d%0d: got v%b a%h, required v0 a00", d, av[d], asc[d]);
      end
    end
    send(8'h12, 0);
    vecs++;
    if (sh[1] !== 1'b1) begin errs++; $display("FAIL shift_set: got %b, required 1", sh[1]); end
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h12, 0);
    vecs++;
    if (sh[0] !== 1'b0) begin errs++; $display("FAIL shift_clr: got %b, required 0", sh[0]); end
    send(8'h1C, 0);
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (asc[d] !== (k == 0 ? 8'h41 : 8'h61)) begin
          errs++; $display("FAIL shift_chars d%0d k%0d: got %h, required %h", d, k, asc[d], (k == 0 ? 8'h41 : 8'h61));
        end
      end
      clk_edge(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_caps();
    logic [7:0] exp_q [4];
    int n [2];
    exp_q = '{8'h41, 8'h31, 8'h61, 8'h21};
    do_reset();
    send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0); send(8'h1C, 0); send(8'h16, 0);
    vecs++;
    if (cp[0] !== 1'b1) begin errs++; $display("FAIL caps_on: got %b, required 1", cp[0]); end
    send(8'h12, 0); send(8'h1C, 0); send(8'h12, 0); send(8'h16, 0);
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (asc[d] !== exp_q[k] || av[d] !== 1'b1) begin
          errs++; $display("FAIL caps_chars d%0d k%0d: got v%b a%h, required v1 a%h", d, k, av[d], asc[d], exp_q[k]);
        end
      end
      clk_edge(1'b0, 8'h00, 1'b1);
    end
    do_reset();
    send(8'h58, 0); send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
    vecs++;
    if (cp[1] !== 1'b1) begin errs++; $display("FAIL caps_repeat: got %b, required 1", cp[1]); end
    do_reset();
    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    n = '{0, 0};
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 2; d++) if (av[d] === 1'b1 && asc[d] === 8'h61) n[d]++;
      clk_edge(1'b0, 8'h00, 1'b1);
    end
    vecs++;
    if (n[0] != 3 || n[1] != 1) begin
      errs++; $display("FAIL autorepeat: got %0d/%0d chars, required 3/1", n[0], n[1]);
    end
  endtask

  task automatic test_ext();
    do_reset();
    send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    send(8'h29, 0); send(8'hE0, 0); send(8'h5A, 0);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b1 || asc[d] !== 8'h20) begin
        errs++; $display("FAIL ext_space d%0d: got v%b a%h, required v1 a20", d, av[d], asc[d]);
      end
    end
    clk_edge(1'b0, 8'h00, 1'b1);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b0) begin errs++; $display("FAIL ext_only_one d%0d: got v%b, required v0", d, av[d]); end
    end
  endtask

  task automatic test_fifo_boundary();
    logic [7:0] exp1 [4];
    exp1 = '{8'h62, 8'h63, 8'h64, 8'h66};
    do_reset();
    clk_edge(1'b0, 8'h00, 1'b1);
    send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); send(8'h23, 0); send(8'h24, 0);
    vecs++;
    if (ov[1] !== 1'b1 || ov[0] !== 1'b0) begin
      errs++; $display("FAIL overflow: got %b/%b, required 0/1", ov[0], ov[1]);
    end
    send(8'h2B, 1);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        vecs++;
        if (asc[1] !== exp1[k]) begin errs++; $display("FAIL full_order k%0d: got %h, required %h", k, asc[1], exp1[k]); end
      end
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (av[d] !== (mcnt[d] != 0) || asc[d] !== m_head(d) || ov[d] !== movf[d]) begin
          errs++; $display("FAIL full_drain d%0d k%0d: got v%b a%h o%b, required v%b a%h o%b", d, k, av[d], asc[d], ov[d], mcnt[d] != 0, m_head(d), movf[d]);
        end
      end
      clk_edge(1'b0, 8'h00, 1'b1);
    end
    send(8'h1C, 1);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b1 || asc[d] !== 8'h61) begin
        errs++; $display("FAIL push_pop_empty d%0d: got v%b a%h, required v1 a61", d, av[d], asc[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h12, 0); send(8'h58, 0); send(8'h1C, 0); send(8'hE0, 0);
    do_reset();
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b0 || sh[d] !== 1'b0 || cp[d] !== 1'b0 || ov[d] !== 1'b0) begin
        errs++; $display("FAIL reset_mid d%0d: got v%b s%b c%b o%b, required all zero", d, av[d], sh[d], cp[d], ov[d]);
      end
    end
    send(8'h1C, 0);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== 1'b1 || asc[d] !== 8'h61) begin
        errs++; $display("FAIL after_reset d%0d: got v%b a%h, required v1 a61", d, av[d], asc[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clk_edge(1'b1, 8'h1C, 1'b0);
    clk_edge(1'b1, 8'h32, 1'b0);
    clk_edge(1'b1, 8'h21, 1'b1);
    clk_edge(1'b0, 8'h00, 1'b0);
    vecs++;
    if (asc[0] !== 8'h62 || asc[1] !== 8'h62) begin
      errs++; $display("FAIL b2b_head: got %h/%h, required 62/62", asc[0], asc[1]);
    end
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (av[d] !== (mcnt[d] != 0) || asc[d] !== m_head(d) || mcnt[d] != 2) begin
        errs++; $display("FAIL b2b_model d%0d: got v%b a%h, required v%b a%h count 2", d, av[d], asc[d], mcnt[d] != 0, m_head(d));
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 30) clk_edge(1'b0, 8'h00, 1'b1);
      else if (r < 42) clk_edge(1'b1, pick_code(), 1'($urandom_range(0, 1)));
      else send(pick_code(), ($urandom_range(0, 3) == 0));
      for (int d = 0; d < 2; d++) begin
        vecs++;
        if (av[d] !== (mcnt[d] != 0) || asc[d] !== m_head(d) || sh[d] !== (m_shl | m_shr) ||
            cp[d] !== m_caps || ov[d] !== movf[d]) begin
          errs++;
          $display("FAIL random it%0d d%0d: got v%b a%h s%b c%b o%b, required v%b a%h s%b c%b o%b",
                   it, d, av[d], asc[d], sh[d], cp[d], ov[d], mcnt[d] != 0, m_head(d), m_shl | m_shr, m_caps, movf[d]);
        end
      end
    end
  endtask

  initial begin
    clrn = 1'b1; sv = 1'b0; rd = 1'b0; sc = 8'h00;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_make_break();
    test_caps();
    test_ext();
    test_fifo_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ps2_keymap_decoder.md
Name: ps2_keymap_decoder

Overview:
- Stateful successor to the combinational scan-code lookup.
- Consumes set-2 scan-code bytes from the PS/2 receiver and tracks make/break (F0) and extended (E0) prefixes, Shift state and Caps Lock.
- Emits case-correct ASCII into a parametrised first-word-fall-through FIFO, which the display/text buffer logic drains.

Parameters:
- FIFO_DEPTH, 8, entries in output FIFO; power of two, ≥2.
- AUTOREPEAT, 1, 1 = repeated make codes of a held key each emit a character; 0 = only the first make after a break emits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clrn  in  1  synchronous active-low reset.
- scan_code  in  8  received scan-code byte.
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
- rd_en  in  1  pop FIFO head this cycle.
- ascii  out  8  FIFO head character; 8'h00 when empty.
- ascii_valid  out  1  FIFO not empty.
- shift_held  out  1  either Shift (12h, 59h) currently down.
- caps_on  out  1  Caps Lock toggle state.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.

Behaviour:
- Reset: when clrn is 0 at a clock edge:
  - FIFO empties; ascii = 00, ascii_valid = 0.
  - shift_held = 0, caps_on = 0, overflow = 0.
  - FSM goes to IDLE; held code is cleared to 00.
  - Reset applies mid-sequence too: a pending F0/E0 prefix is discarded.
- FSM states: IDLE, BRK, EXT, EXT_BRK. State advances only on scan_valid; otherwise it holds.
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - Any other code -> make event, stay in IDLE.
- BRK: any code -> break event, -> IDLE.
- EXT transitions:
  - F0 -> EXT_BRK.
  - Any other code -> IDLE, nothing emitted (arrows, keypad Enter etc. ignored).
- EXT_BRK: any code -> IDLE, no effect.
- Shift: left (12h) and right (59h) Shift are tracked with separate flags; shift_held = OR of the two flags. A make sets its flag; a break clears it. Shift keys emit nothing.
- Caps Lock (58h):
  - A make toggles caps_on only if held code ≠ 58h; Caps Lock keyboard repeat must not re-toggle.
  - Caps Lock emits nothing.
- Held code:
  - A make of any key sets held code = scan_code.
  - A break whose code equals held code clears it to 00.
- Character make (any code not covered above):
  - Suppressed when AUTOREPEAT = 0 and scan_code == held code.
  - Otherwise look up the character:
    - Letters: lowercase when (shift_held XOR caps_on) = 0, uppercase (subtract 20h) when 1.
    - Digits 1..0 unshifted: 31h..39h, 30h. Shifted: ! @ # $ % ^ & * ( ), i.e. 21 40 23 24 25 5E 26 2A 28 29. Caps does not affect digits.
    - Space 29h -> 20h; Enter 5Ah -> 0Dh; Backspace 66h -> 08h. Shift and caps do not affect these.
    - Codes with no entry produce 00 and are not pushed.
  - The shift value used is the state before this byte.
- FIFO push and pop:
  - A push occurs in the cycle after the scan_valid that completes a make.
  - Latency: scan_valid at edge N -> ascii_valid = 1 and ascii = char after edge N+1.
  - ascii is combinational from the head entry.
- FIFO boundary conditions:
  - rd_en while empty: ignored.
  - Push while full with no pop: character dropped, overflow set to 1. overflow stays 1 until reset.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- scan_valid with clrn = 0: ignored.

Test Plan:
- Reset then codes 1C, F0, 1C -> one entry 61h ('a'); ascii_valid = 1 one cycle after the 1C strobe; rd_en -> ascii_valid = 0, ascii = 00.
- 12, 1C, F0 1C, F0 12, 1C -> 41h ('A') then 61h; shift_held goes 1 then back to 0.
- 58, F0 58, 1C, 16 -> 41h, 31h; caps_on = 1; then 12, 1C -> 61h (shift cancels caps), 12, 16 -> 21h ('!').
- 58, 58, F0 58 (key repeat) -> caps_on = 1 (not toggled twice). With AUTOREPEAT = 0, 1C 1C 1C F0 1C -> one 61h; with AUTOREPEAT = 1 -> three 61h.
- E0 75, E0 F0 75, 29 -> only 20h queued; FSM back in IDLE after each sequence.
- FIFO_DEPTH = 4: push 5 characters without reads -> 4 entries, overflow = 1; pop while pushing at full -> no further overflow increment, order preserved. Assert clrn low after an E0 prefix -> FIFO empty, flags 0, next 1C -> 61h.
